// File: rtl/rev_pkg.sv
// Shared definitions for the reversible cascade sequencer.
//   - FSM state encoding (IDLE / RUN / DONE)
//   - Direction constants for forward (compute) / reverse (uncompute)
//   - Default sizing constants
package rev_pkg;

  localparam int DEF_WIDTH = 6;
  localparam int DEF_DEPTH = 8;
  localparam int DEF_PTR_W = 3;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mct_gate.sv
// Combinational multi-controlled XOR (MCT) gate.
// Ports:
//   word     in  WIDTH  operand
//   ctrl     in  WIDTH  control mask; gate fires when all ctrl bits are set in word
//   tgt      in  WIDTH  target mask; bits overlapping ctrl are ignored
//   word_out out WIDTH  word after the gate
module mct_gate
  import rev_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] word,
  input  logic [WIDTH-1:0] ctrl,
  input  logic [WIDTH-1:0] tgt,
  output logic [WIDTH-1:0] word_out
);

  logic             fire_s;
  logic [WIDTH-1:0] flip_s;

  // Fire test and flip mask; stripping control bits from the target keeps the gate self-inverse.
  always_comb begin
    fire_s = ((word & ctrl) == ctrl);
    flip_s = tgt & ~ctrl;
    if (fire_s) begin
      word_out = word ^ flip_s;
    end else begin
      word_out = word;
    end
  end

endmodule

// File: rtl/rev_cascade_seq.sv
// Programmable compute/uncompute sequencer: applies a stored cascade of MCT
// gates to a word, one gate per clock, forward (slot 0 up) or reverse
// (slot len-1 down).
// Ports:
//   clk, rst_n                clock, asynchronous active-low reset
//   prog_we/addr/ctrl/tgt     program-slot write (accepted only in IDLE)
//   start_valid/start_ready   start handshake; dir, len, data_in sampled on start
//   out_valid/out_ready       result handshake; data_out is the working register
//   busy                      high while gates are being applied
module rev_cascade_seq
  import rev_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int PTR_W = DEF_PTR_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             prog_we,
  input  logic [PTR_W-1:0] prog_addr,
  input  logic [WIDTH-1:0] prog_ctrl,
  input  logic [WIDTH-1:0] prog_tgt,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic             dir,
  input  logic [PTR_W:0]   len,
  input  logic [WIDTH-1:0] data_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             busy
);

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  state_t           state_r, state_nxt_s;
  logic [WIDTH-1:0] word_r, word_nxt_s;
  logic             dir_r, dir_nxt_s;
  logic [PTR_W-1:0] ptr_r, ptr_nxt_s;
  logic [PTR_W:0]   rem_r, rem_nxt_s;
  logic             start_ready_r, out_valid_r, busy_r;

  logic [WIDTH-1:0] ctrl_mem_r [DEPTH];
  logic [WIDTH-1:0] tgt_mem_r  [DEPTH];

  logic [PTR_W:0]   eff_len_s;
  logic [PTR_W:0]   eff_len_m1_s;
  logic             prog_hit_s;
  logic [WIDTH-1:0] gate_out_s;

  // Clamp requested length to the store depth and precompute the reverse start slot.
  always_comb begin
    if (len > DEPTH_C) begin
      eff_len_s = DEPTH_C;
    end else begin
      eff_len_s = len;
    end
    eff_len_m1_s = eff_len_s - {{PTR_W{1'b0}}, 1'b1};
  end

  // Program writes are honoured only in IDLE and only for in-range slots.
  always_comb begin
    if ((state_r == IDLE) && prog_we && ({1'b0, prog_addr} < DEPTH_C)) begin
      prog_hit_s = 1'b1;
    end else begin
      prog_hit_s = 1'b0;
    end
  end

  // Gate applied in RUN reads the registered store at the current pointer.
  mct_gate #(.WIDTH(WIDTH)) u_gate (
    .word     (word_r),
    .ctrl     (ctrl_mem_r[ptr_r]),
    .tgt      (tgt_mem_r[ptr_r]),
    .word_out (gate_out_s)
  );

  // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_nxt_s = state_r;
    word_nxt_s  = word_r;
    dir_nxt_s   = dir_r;
    ptr_nxt_s   = ptr_r;
    rem_nxt_s   = rem_r;
    case (state_r)
      IDLE: begin
        if (start_valid) begin
          word_nxt_s = data_in;
          dir_nxt_s  = dir;
          rem_nxt_s  = eff_len_s;
          if (eff_len_s == {(PTR_W+1){1'b0}}) begin
            state_nxt_s = DONE;
            ptr_nxt_s   = {PTR_W{1'b0}};
          end else begin
            state_nxt_s = RUN;
            if (dir == DIR_REV) begin
              ptr_nxt_s = eff_len_m1_s[PTR_W-1:0];
            end else begin
              ptr_nxt_s = {PTR_W{1'b0}};
            end
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        word_nxt_s = gate_out_s;
        rem_nxt_s  = rem_r - {{PTR_W{1'b0}}, 1'b1};
        // Last gate: finish on this edge and leave the pointer in range.
        if (rem_r == {{PTR_W{1'b0}}, 1'b1}) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
          if (dir_r == DIR_REV) begin
            ptr_nxt_s = ptr_r - {{(PTR_W-1){1'b0}}, 1'b1};
          end else begin
            ptr_nxt_s = ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      word_r        <= {WIDTH{1'b0}};
      dir_r         <= DIR_FWD;
      ptr_r         <= {PTR_W{1'b0}};
      rem_r         <= {(PTR_W+1){1'b0}};
      start_ready_r <= 1'b1;
      out_valid_r   <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      word_r        <= word_nxt_s;
      dir_r         <= dir_nxt_s;
      ptr_r         <= ptr_nxt_s;
      rem_r         <= rem_nxt_s;
      start_ready_r <= (state_nxt_s == IDLE);
      out_valid_r   <= (state_nxt_s == DONE);
      busy_r        <= (state_nxt_s == RUN);
    end
  end

  // Program store; reset clears every slot to the identity gate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ctrl_mem_r[i] <= {WIDTH{1'b0}};
        tgt_mem_r[i]  <= {WIDTH{1'b0}};
      end
    end else begin
      if (prog_hit_s) begin
        ctrl_mem_r[prog_addr] <= prog_ctrl;
        tgt_mem_r[prog_addr]  <= prog_tgt;
      end
    end
  end

  assign start_ready = start_ready_r;
  assign out_valid   = out_valid_r;
  assign busy        = busy_r;
  assign data_out    = word_r;

endmodule

// File: tb/tb_rev_cascade_seq.sv
module tb_rev_cascade_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       prog_we = 1'b0;
  logic [2:0] prog_addr = 3'd0;
  logic [5:0] prog_ctrl = 6'd0;
  logic [5:0] prog_tgt = 6'd0;
  logic       start_valid = 1'b0;
  logic       start_ready;
  logic       dir = 1'b0;
  logic [3:0] len = 4'd0;
  logic [5:0] data_in = 6'd0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [5:0] data_out;
  logic       busy;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  rev_cascade_seq dut (
    .clk(clk), .rst_n(rst_n),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_ctrl(prog_ctrl), .prog_tgt(prog_tgt),
    .start_valid(start_valid), .start_ready(start_ready),
    .dir(dir), .len(len), .data_in(data_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .busy(busy)
  );

  typedef struct {
    int         prog;
    logic       dr;
    logic [3:0] ln;
    logic [5:0] din;
    logic [5:0] dout;
    int         lat;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic write_slot(input logic [2:0] a, input logic [5:0] c, input logic [5:0] t);
    prog_we = 1'b1; prog_addr = a; prog_ctrl = c; prog_tgt = t;
    @(posedge clk); #1;
    prog_we = 1'b0;
  endtask

  // 0: single gate, 1: three-slot chain, 2: overlapping masks, 3: all clear, 4: empty-ctrl gate
  task automatic load_prog(input int p);
    for (int i = 0; i < 8; i++) write_slot(3'(i), 6'd0, 6'd0);
    case (p)
      0: write_slot(3'd0, 6'b000011, 6'b111100);
      1: begin
        write_slot(3'd0, 6'b000001, 6'b000010);
        write_slot(3'd1, 6'b000010, 6'b000100);
        write_slot(3'd2, 6'b000110, 6'b001000);
      end
      2: write_slot(3'd0, 6'b000001, 6'b000011);
      4: write_slot(3'd0, 6'b000000, 6'b100000);
      default: ;
    endcase
  endtask

  task automatic run_to_done(input logic d, input logic [3:0] l, input logic [5:0] di,
                             output logic [5:0] res, output int cyc);
    start_valid = 1'b1; dir = d; len = l; data_in = di;
    @(posedge clk); #1;
    start_valid = 1'b0;
    cyc = 1;
    if (l != 4'd0) begin
      check("busy_after_start", int'(busy), 1);
      check("start_ready_in_run", int'(start_ready), 0);
    end
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!out_valid) check("done_timeout", 0, 1);
    res = data_out;
  endtask

  task automatic accept();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  vec_t       vecs [12];
  logic [5:0] res;
  int         cyc;

  initial begin
    vecs[0]  = '{0, 1'b0, 4'd1,  6'b000011, 6'b111111, 2};
    vecs[1]  = '{0, 1'b0, 4'd1,  6'b000010, 6'b000010, 2};
    vecs[2]  = '{1, 1'b0, 4'd3,  6'b000001, 6'b001111, 4};
    vecs[3]  = '{1, 1'b1, 4'd3,  6'b001111, 6'b000001, 4};
    vecs[4]  = '{1, 1'b0, 4'd2,  6'b000001, 6'b000111, 3};
    vecs[5]  = '{1, 1'b1, 4'd2,  6'b000111, 6'b000001, 3};
    vecs[6]  = '{1, 1'b0, 4'd0,  6'b101010, 6'b101010, 1};
    vecs[7]  = '{1, 1'b0, 4'd12, 6'b000001, 6'b001111, 9};
    vecs[8]  = '{1, 1'b1, 4'd12, 6'b001111, 6'b000001, 9};
    vecs[9]  = '{2, 1'b0, 4'd1,  6'b000001, 6'b000011, 2};
    vecs[10] = '{2, 1'b0, 4'd1,  6'b000000, 6'b000000, 2};
    vecs[11] = '{4, 1'b0, 4'd1,  6'b000000, 6'b100000, 2};

    #12;
    check("rst_data_out", int'(data_out), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_start_ready", int'(start_ready), 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      load_prog(vecs[i].prog);
      run_to_done(vecs[i].dr, vecs[i].ln, vecs[i].din, res, cyc);
      check($sformatf("vec%0d_data", i), int'(res), int'(vecs[i].dout));
      check($sformatf("vec%0d_latency", i), cyc, vecs[i].lat);
      accept();
      check($sformatf("vec%0d_idle", i), int'(start_ready), 1);
    end

    // Backpressure: DONE holds, start is ignored, release returns to IDLE with result held.
    load_prog(1);
    run_to_done(1'b0, 4'd3, 6'b000001, res, cyc);
    for (int k = 0; k < 5; k++) begin
      start_valid = 1'b1; data_in = 6'b111111; len = 4'd0;
      @(posedge clk); #1;
      check($sformatf("bp%0d_valid", k), int'(out_valid), 1);
      check($sformatf("bp%0d_data", k), int'(data_out), 6'b001111);
      check($sformatf("bp%0d_start_ready", k), int'(start_ready), 0);
    end
    start_valid = 1'b0;
    accept();
    check("bp_release_ready", int'(start_ready), 1);
    check("bp_release_valid", int'(out_valid), 0);
    check("bp_idle_hold", int'(data_out), 6'b001111);

    // Program write during RUN is dropped.
    load_prog(0);
    start_valid = 1'b1; dir = 1'b0; len = 4'd1; data_in = 6'b000011;
    @(posedge clk); #1;
    start_valid = 1'b0;
    prog_we = 1'b1; prog_addr = 3'd0; prog_ctrl = 6'd0; prog_tgt = 6'd0;
    @(posedge clk); #1;
    prog_we = 1'b0;
    check("runwr_valid", int'(out_valid), 1);
    check("runwr_data", int'(data_out), 6'b111111);
    accept();
    run_to_done(1'b0, 4'd1, 6'b000011, res, cyc);
    check("runwr_store_kept", int'(res), 6'b111111);
    accept();

    // Write and start in the same IDLE cycle: first RUN cycle sees the new slot.
    load_prog(3);
    prog_we = 1'b1; prog_addr = 3'd0; prog_ctrl = 6'd0; prog_tgt = 6'b000001;
    start_valid = 1'b1; dir = 1'b0; len = 4'd1; data_in = 6'b000000;
    @(posedge clk); #1;
    prog_we = 1'b0; start_valid = 1'b0;
    @(posedge clk); #1;
    check("samecyc_valid", int'(out_valid), 1);
    check("samecyc_data", int'(data_out), 6'b000001);
    accept();

    // Reset in the second RUN cycle aborts and clears the store.
    load_prog(1);
    start_valid = 1'b1; dir = 1'b0; len = 4'd3; data_in = 6'b000001;
    @(posedge clk); #1;
    start_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_data", int'(data_out), 0);
    check("midrst_valid", int'(out_valid), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_ready", int'(start_ready), 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_to_done(1'b0, 4'd3, 6'b000001, res, cyc);
    check("postrst_identity", int'(res), 6'b000001);
    check("postrst_latency", cyc, 4);
    accept();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
